// File: rtl/cpu_pkg.sv
// Opcode, phase and FSM-state definitions shared by the CPU sequencer and the instruction decoder.
package cpu_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_STA = 4'b0000;
  localparam logic [OPC_W-1:0] OP_JMP = 4'b0001;
  localparam logic [OPC_W-1:0] OP_STP = 4'b0010;
  localparam logic [OPC_W-1:0] OP_LDA = 4'b0011;
  localparam logic [OPC_W-1:0] OP_JMS = 4'b0100;
  localparam logic [OPC_W-1:0] OP_BBL = 4'b0101;
  localparam logic [OPC_W-1:0] OP_JEQ = 4'b0110;
  localparam logic [OPC_W-1:0] OP_MUL = 4'b1101;
  localparam logic [OPC_W-1:0] OP_LDR = 4'b1110;

  localparam logic [3:0] PH_NONE  = 4'b0000;
  localparam logic [3:0] PH_FETCH = 4'b0001;
  localparam logic [3:0] PH_EXEC1 = 4'b0010;
  localparam logic [3:0] PH_EXEC2 = 4'b0100;
  localparam logic [3:0] PH_EXEC3 = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC1 = 3'd2,
    ST_EXEC2 = 3'd3,
    ST_EXEC3 = 3'd4
  } seq_state_e;

  // Instructions that need a third phase.
  function automatic logic op_is_ext(input logic [OPC_W-1:0] op);
    return (op == OP_LDA) || (op == OP_LDR) || (op == OP_MUL);
  endfunction

  // Instructions that need a fourth phase.
  function automatic logic op_is_long(input logic [OPC_W-1:0] op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/seq_step_edge.sv
// Rising-edge detector for a level-type single-step request.
module seq_step_edge (
  input  logic clk,
  input  logic reset,
  input  logic step_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= step_i;
  end

  assign rise_o = step_i & ~prev_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Phase controller: one-hot fetch/exec phases, instruction register, run/halt/single-step.
// Optional perf counters (retired_cnt, stall_cnt) when CPU_SEQ_PERF_EN is defined.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW       = 4,
  parameter bit STEP_SYNC = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           run,
  input  logic           step,
  input  logic           mem_ready,
  input  logic [OPW-1:0] instr_in,
  output logic [3:0]     state,
  output logic [OPW-1:0] inst,
  output logic           halted,
`ifdef CPU_SEQ_PERF_EN
  output logic [15:0]    retired_cnt,
  output logic [15:0]    stall_cnt,
`endif
  output logic           instr_done
);

  seq_state_e     fsm_q, fsm_d;
  logic [OPW-1:0] ir_q, ir_d;
  logic           single_q, single_d;
  logic           step_ev;
  logic           adv;
  logic           last;
  logic           ext, long_op;
  logic [3:0]     phase;

  generate
    if (STEP_SYNC) begin : g_step_sync
      seq_step_edge u_edge (
        .clk    (clk),
        .reset  (reset),
        .step_i (step),
        .rise_o (step_ev)
      );
    end else begin : g_step_pulse
      assign step_ev = step;
    end
  endgenerate

  assign adv     = mem_ready;
  assign ext     = op_is_ext(OPC_W'(ir_q));
  assign long_op = op_is_long(OPC_W'(ir_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q    <= ST_IDLE;
      ir_q     <= '0;
      single_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      ir_q     <= ir_d;
      single_q <= single_d;
    end
  end

  always_comb begin
    fsm_d    = fsm_q;
    ir_d     = ir_q;
    single_d = single_q;
    last     = 1'b0;
    phase    = PH_NONE;
    case (fsm_q)
      ST_IDLE: begin
        // run has priority; a simultaneous step does not arm single-shot
        if (run) begin
          fsm_d    = ST_FETCH;
          single_d = 1'b0;
        end else if (step_ev) begin
          fsm_d    = ST_FETCH;
          single_d = 1'b1;
        end
      end
      ST_FETCH: begin
        phase = PH_FETCH;
        if (adv) begin
          ir_d  = instr_in;
          fsm_d = ST_EXEC1;
        end
      end
      ST_EXEC1: begin
        phase = PH_EXEC1;
        if (adv) begin
          if (ext) fsm_d = ST_EXEC2;
          else     last  = 1'b1;
        end
      end
      ST_EXEC2: begin
        phase = PH_EXEC2;
        if (adv) begin
          if (long_op) fsm_d = ST_EXEC3;
          else         last  = 1'b1;
        end
      end
      ST_EXEC3: begin
        phase = PH_EXEC3;
        if (adv) last = 1'b1;
      end
      default: fsm_d = ST_IDLE;
    endcase
    // run is only consulted at an instruction boundary, so nothing is truncated
    if (last) begin
      if (single_q || !run) begin
        fsm_d    = ST_IDLE;
        single_d = 1'b0;
      end else begin
        fsm_d = ST_FETCH;
      end
    end
  end

  assign state      = phase & {4{adv}};
  assign inst       = ir_q;
  assign halted     = (fsm_q == ST_IDLE);
  assign instr_done = last;

`ifdef CPU_SEQ_PERF_EN
  logic [15:0] retired_q, stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      if (last && retired_q != 16'hFFFF)
        retired_q <= retired_q + 16'd1;
      if (fsm_q != ST_IDLE && !mem_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer (counters checked when CPU_SEQ_PERF_EN is defined).
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset, run, step, mem_ready;
  logic [3:0] instr_in;
  logic [3:0] state;
  logic [3:0] inst;
  logic       halted, instr_done;
`ifdef CPU_SEQ_PERF_EN
  logic [15:0] retired_cnt, stall_cnt;
`endif

  int npass = 0;
  int ntotal = 0;

  cpu_sequencer #(.OPW(4), .STEP_SYNC(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .step       (step),
    .mem_ready  (mem_ready),
    .instr_in   (instr_in),
    .state      (state),
    .inst       (inst),
    .halted     (halted),
`ifdef CPU_SEQ_PERF_EN
    .retired_cnt(retired_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // settle, then check phase vector, done pulse and halted flag
  task automatic expo(input string tag, input logic [3:0] st, input logic dn, input logic hl);
    #1;
    chk({tag, ".state"}, 16'(state), 16'(st));
    chk({tag, ".done"},  16'(instr_done), 16'(dn));
    chk({tag, ".halted"}, 16'(halted), 16'(hl));
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0; mem_ready = 1'b1; instr_in = OP_STA;
    #12;
    chk("rst.state", 16'(state), 16'h0);
    chk("rst.halted", 16'(halted), 16'h1);
    chk("rst.inst", 16'(inst), 16'h0);
    chk("rst.done", 16'(instr_done), 16'h0);
    reset = 1'b0;
    cyc();

    // STA, JMP: two phases each
    run = 1'b1;
    expo("idle_run", PH_NONE, 1'b0, 1'b1);
    cyc(); instr_in = OP_STA;
    expo("sta_f", PH_FETCH, 1'b0, 1'b0);
    chk("sta_f.inst", 16'(inst), 16'h0);
    cyc(); instr_in = OP_JMP;
    expo("sta_e1", PH_EXEC1, 1'b1, 1'b0);
    chk("sta_e1.inst", 16'(inst), 16'h0);
    cyc();
    expo("jmp_f", PH_FETCH, 1'b0, 1'b0);
    cyc();
    expo("jmp_e1", PH_EXEC1, 1'b1, 1'b0);
    chk("jmp_e1.inst", 16'(inst), 16'h1);

    // LDA: three phases
    cyc(); instr_in = OP_LDA;
    expo("lda_f", PH_FETCH, 1'b0, 1'b0);
    cyc();
    expo("lda_e1", PH_EXEC1, 1'b0, 1'b0);
    cyc();
    expo("lda_e2", PH_EXEC2, 1'b1, 1'b0);

    // MUL: four phases
    cyc(); instr_in = OP_MUL;
    expo("mul_f", PH_FETCH, 1'b0, 1'b0);
    cyc();
    expo("mul_e1", PH_EXEC1, 1'b0, 1'b0);
    cyc();
    expo("mul_e2", PH_EXEC2, 1'b0, 1'b0);
    cyc();
    expo("mul_e3", PH_EXEC3, 1'b1, 1'b0);
    chk("mul_e3.inst", 16'(inst), 16'hD);

    // MUL with three wait states in EXEC2
    cyc();
    expo("smul_f", PH_FETCH, 1'b0, 1'b0);
    cyc();
    expo("smul_e1", PH_EXEC1, 1'b0, 1'b0);
    cyc(); mem_ready = 1'b0;
    expo("smul_st1", PH_NONE, 1'b0, 1'b0);
    cyc();
    expo("smul_st2", PH_NONE, 1'b0, 1'b0);
    cyc();
    expo("smul_st3", PH_NONE, 1'b0, 1'b0);
    cyc(); mem_ready = 1'b1;
    expo("smul_e2", PH_EXEC2, 1'b0, 1'b0);
    cyc();
    expo("smul_e3", PH_EXEC3, 1'b1, 1'b0);
`ifdef CPU_SEQ_PERF_EN
    chk("perf.stall", stall_cnt, 16'd3);
    chk("perf.retired", retired_cnt, 16'd4);
`endif

    // run dropped during EXEC1 of MUL: instruction still completes
    cyc();
    expo("dmul_f", PH_FETCH, 1'b0, 1'b0);
    cyc(); run = 1'b0;
    expo("dmul_e1", PH_EXEC1, 1'b0, 1'b0);
    cyc();
    expo("dmul_e2", PH_EXEC2, 1'b0, 1'b0);
    cyc();
    expo("dmul_e3", PH_EXEC3, 1'b1, 1'b0);
    cyc();
    expo("dmul_idle", PH_NONE, 1'b0, 1'b1);

    // single step of LDR; a second step edge while busy is dropped
    step = 1'b1;
    expo("stp_idle", PH_NONE, 1'b0, 1'b1);
    cyc(); instr_in = OP_LDR;
    expo("ldr_f", PH_FETCH, 1'b0, 1'b0);
    cyc(); step = 1'b0;
    expo("ldr_e1", PH_EXEC1, 1'b0, 1'b0);
    cyc(); step = 1'b1;
    expo("ldr_e2", PH_EXEC2, 1'b1, 1'b0);
    cyc();
    expo("ldr_idle", PH_NONE, 1'b0, 1'b1);
    chk("ldr_idle.inst", 16'(inst), 16'hE);
    cyc();
    expo("ldr_noqueue", PH_NONE, 1'b0, 1'b1);
    step = 1'b0;
    cyc();

    // run and step together: continuous run, not single-shot
    run = 1'b1; step = 1'b1;
    expo("rs_idle", PH_NONE, 1'b0, 1'b1);
    cyc(); instr_in = OP_STA; step = 1'b0;
    expo("rs_f", PH_FETCH, 1'b0, 1'b0);
    cyc(); instr_in = OP_LDA;
    expo("rs_e1", PH_EXEC1, 1'b1, 1'b0);
    cyc();
    expo("rs_f2", PH_FETCH, 1'b0, 1'b0);
    cyc();
    expo("rs2_e1", PH_EXEC1, 1'b0, 1'b0);
    chk("rs2_e1.inst", 16'(inst), 16'h3);
    cyc();
    expo("rs2_e2", PH_EXEC2, 1'b1, 1'b0);

    // async reset mid-EXEC2
    reset = 1'b1;
    #1;
    chk("arst.state", 16'(state), 16'h0);
    chk("arst.halted", 16'(halted), 16'h1);
    chk("arst.inst", 16'(inst), 16'h0);
    chk("arst.done", 16'(instr_done), 16'h0);
`ifdef CPU_SEQ_PERF_EN
    chk("arst.stall", stall_cnt, 16'd0);
    chk("arst.retired", retired_cnt, 16'd0);
`endif
    run = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    expo("post_rst", PH_NONE, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
